// File: rtl/axis_fifo_w_thresh.sv
// axis_fifo_w_thresh: single-clock AXI4-Stream FIFO with occupancy and watermark status.
//
// Storage is a 2^ADDR_WIDTH entry memory followed by one output register, so the
// FIFO holds 2^ADDR_WIDTH + 1 beats in total. Optional frame mode holds the output
// back until a complete frame (tlast) is in memory. An oversize frame that fills the
// memory without a tlast is released anyway, so the FIFO cannot deadlock.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   s_axis_*                           input stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*                           output stream, driven from the output register
//   cfg_almost_full_thresh             almost-full level, unsigned ADDR_WIDTH+1 bits
//   cfg_almost_empty_thresh            almost-empty level, unsigned ADDR_WIDTH+1 bits
//   stat_clear                         pulse: high-water mark := occupancy, stall count := 0
//   status_line_count                  registered memory occupancy
//   status_frame_count                 registered frames held (memory + output register)
//   status_almost_full / _almost_empty registered threshold flags
//   status_high_water                  peak occupancy since reset or stat_clear
//   status_stall_count                 saturating count of s_axis stall cycles
module axis_fifo_w_thresh #(
    parameter int DEPTH           = 4096,
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH      = ((DATA_WIDTH + 7) / 8),
    parameter int USER_ENABLE     = 1,
    parameter int USER_WIDTH      = 1,
    parameter int FRAME_FIFO      = 0,
    parameter int STALL_CNT_WIDTH = 16,
    parameter int ADDR_WIDTH      = (KEEP_ENABLE != 0 && KEEP_WIDTH > 1) ?
                                    $clog2(DEPTH / KEEP_WIDTH) : $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    input  logic [ADDR_WIDTH:0]        cfg_almost_full_thresh,
    input  logic [ADDR_WIDTH:0]        cfg_almost_empty_thresh,
    input  logic                       stat_clear,
    output logic [ADDR_WIDTH:0]        status_line_count,
    output logic [ADDR_WIDTH:0]        status_frame_count,
    output logic                       status_almost_full,
    output logic                       status_almost_empty,
    output logic [ADDR_WIDTH:0]        status_high_water,
    output logic [STALL_CNT_WIDTH-1:0] status_stall_count
);

    localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int LAST_BIT  = DATA_WIDTH + KEEP_WIDTH;
    localparam int ENTRY_W   = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ZERO_OCC = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0] FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};

    // Entry layout: {tuser, tlast, tkeep, tdata}
    logic [ENTRY_W-1:0]         mem_r [MEM_DEPTH];
    logic [ADDR_WIDTH:0]        wr_ptr_r, rd_ptr_r, mem_frames_r;
    logic                       in_frame_r, oversize_r, m_valid_r;
    logic [DATA_WIDTH-1:0]      out_data_r;
    logic [KEEP_WIDTH-1:0]      out_keep_r;
    logic                       out_last_r;
    logic [USER_WIDTH-1:0]      out_user_r;
    logic [ADDR_WIDTH:0]        line_r, frame_r, hw_r;
    logic                       af_r, ae_r;
    logic [STALL_CNT_WIDTH-1:0] stall_r;

    logic [ADDR_WIDTH:0]        occ_s, frames_s, mem_frames_next_s, hw_next_s;
    logic                       full_s, empty_s, rel_s, ready_s, wr_en_s, rd_en_s;
    logic                       rd_last_s, wr_last_s, rd_last_tk_s, stall_s;
    logic [ENTRY_W-1:0]         rd_entry_s;
    logic [STALL_CNT_WIDTH-1:0] stall_next_s;

    // Occupancy, handshakes, release gating and next values for counters
    always_comb begin
        occ_s   = wr_ptr_r - rd_ptr_r;
        full_s  = (occ_s == FULL_OCC);
        empty_s = (occ_s == ZERO_OCC);
        if (FRAME_FIFO != 0) begin
            // A started frame always drains; oversize frames are forced out
            rel_s = (mem_frames_r != ZERO_OCC) || in_frame_r || oversize_r;
        end else begin
            rel_s = 1'b1;
        end
        ready_s      = !full_s && rst_n;
        wr_en_s      = s_axis_tvalid && ready_s;
        rd_en_s      = (m_axis_tready || !m_valid_r) && !empty_s && rel_s;
        rd_entry_s   = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
        rd_last_s    = rd_entry_s[LAST_BIT];
        wr_last_s    = wr_en_s && s_axis_tlast;
        rd_last_tk_s = rd_en_s && rd_last_s;
        frames_s     = mem_frames_r + {{ADDR_WIDTH{1'b0}}, (m_valid_r && out_last_r)};
        stall_s      = s_axis_tvalid && !ready_s;
        case ({wr_last_s, rd_last_tk_s})
            2'b10:   mem_frames_next_s = mem_frames_r + PTR_ONE;
            2'b01:   mem_frames_next_s = mem_frames_r - PTR_ONE;
            default: mem_frames_next_s = mem_frames_r;
        endcase
        if (stat_clear) begin
            hw_next_s = occ_s;
        end else if (occ_s > hw_r) begin
            hw_next_s = occ_s;
        end else begin
            hw_next_s = hw_r;
        end
        if (stat_clear) begin
            stall_next_s = {STALL_CNT_WIDTH{1'b0}};
        end else if (stall_s && (stall_r != STALL_MAX)) begin
            stall_next_s = stall_r + STALL_ONE;
        end else begin
            stall_next_s = stall_r;
        end
    end

    // Memory write port; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Output register payload, loaded from the head of memory
    always_ff @(posedge clk) begin
        if (rd_en_s) begin
            {out_user_r, out_last_r, out_keep_r, out_data_r} <= rd_entry_s;
        end
    end

    // Pointers, frame bookkeeping and output valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r     <= {(ADDR_WIDTH + 1){1'b0}};
            rd_ptr_r     <= {(ADDR_WIDTH + 1){1'b0}};
            mem_frames_r <= {(ADDR_WIDTH + 1){1'b0}};
            in_frame_r   <= 1'b0;
            oversize_r   <= 1'b0;
            m_valid_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                in_frame_r <= !rd_last_s;
                m_valid_r  <= 1'b1;
            end else if (m_axis_tready) begin
                m_valid_r  <= 1'b0;
            end
            mem_frames_r <= mem_frames_next_s;
            // Memory full with no complete frame: release it to avoid deadlock
            if (rd_last_tk_s) begin
                oversize_r <= 1'b0;
            end else if (full_s && (mem_frames_r == ZERO_OCC)) begin
                oversize_r <= 1'b1;
            end
        end
    end

    // Status registers, one cycle behind the pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r  <= {(ADDR_WIDTH + 1){1'b0}};
            frame_r <= {(ADDR_WIDTH + 1){1'b0}};
            hw_r    <= {(ADDR_WIDTH + 1){1'b0}};
            af_r    <= 1'b0;
            ae_r    <= 1'b0;
            stall_r <= {STALL_CNT_WIDTH{1'b0}};
        end else begin
            line_r  <= occ_s;
            frame_r <= frames_s;
            af_r    <= (occ_s >= cfg_almost_full_thresh);
            ae_r    <= (occ_s <= cfg_almost_empty_thresh);
            hw_r    <= hw_next_s;
            stall_r <= stall_next_s;
        end
    end

    assign s_axis_tready       = ready_s;
    assign m_axis_tvalid       = m_valid_r;
    assign m_axis_tdata        = out_data_r;
    assign m_axis_tlast        = out_last_r;
    assign m_axis_tkeep        = (KEEP_ENABLE != 0) ? out_keep_r : {KEEP_WIDTH{1'b1}};
    assign m_axis_tuser        = (USER_ENABLE != 0) ? out_user_r : {USER_WIDTH{1'b0}};
    assign status_line_count   = line_r;
    assign status_frame_count  = frame_r;
    assign status_almost_full  = af_r;
    assign status_almost_empty = ae_r;
    assign status_high_water   = hw_r;
    assign status_stall_count  = stall_r;

endmodule

// File: tb/tb_axis_fifo_w_thresh.sv
// tb_axis_fifo_w_thresh: bench for axis_fifo_w_thresh with DEPTH=16, DATA_WIDTH=8.
// Instance u_str runs streaming mode with a 4-bit stall counter; u_frm runs frame mode.
module tb_axis_fifo_w_thresh;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Streaming instance signals
    logic [7:0] a_sd, a_md;
    logic [0:0] a_sk, a_mk, a_su, a_mu;
    logic       a_sv, a_sr, a_sl, a_mv, a_mr, a_ml, a_clr, a_af, a_ae;
    logic [4:0] a_afth, a_aeth, a_line, a_frm, a_hw;
    logic [3:0] a_stall;

    // Frame instance signals
    logic [7:0]  f_sd, f_md;
    logic [0:0]  f_sk, f_mk, f_su, f_mu;
    logic        f_sv, f_sr, f_sl, f_mv, f_mr, f_ml, f_clr, f_af, f_ae;
    logic [4:0]  f_afth, f_aeth, f_line, f_frm, f_hw;
    logic [15:0] f_stall;

    axis_fifo_w_thresh #(.DEPTH(16), .DATA_WIDTH(8), .FRAME_FIFO(0), .STALL_CNT_WIDTH(4)) u_str (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
        .s_axis_tlast(a_sl), .s_axis_tuser(a_su),
        .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tvalid(a_mv), .m_axis_tready(a_mr),
        .m_axis_tlast(a_ml), .m_axis_tuser(a_mu),
        .cfg_almost_full_thresh(a_afth), .cfg_almost_empty_thresh(a_aeth), .stat_clear(a_clr),
        .status_line_count(a_line), .status_frame_count(a_frm), .status_almost_full(a_af),
        .status_almost_empty(a_ae), .status_high_water(a_hw), .status_stall_count(a_stall));

    axis_fifo_w_thresh #(.DEPTH(16), .DATA_WIDTH(8), .FRAME_FIFO(1), .STALL_CNT_WIDTH(16)) u_frm (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(f_sd), .s_axis_tkeep(f_sk), .s_axis_tvalid(f_sv), .s_axis_tready(f_sr),
        .s_axis_tlast(f_sl), .s_axis_tuser(f_su),
        .m_axis_tdata(f_md), .m_axis_tkeep(f_mk), .m_axis_tvalid(f_mv), .m_axis_tready(f_mr),
        .m_axis_tlast(f_ml), .m_axis_tuser(f_mu),
        .cfg_almost_full_thresh(f_afth), .cfg_almost_empty_thresh(f_aeth), .stat_clear(f_clr),
        .status_line_count(f_line), .status_frame_count(f_frm), .status_almost_full(f_af),
        .status_almost_empty(f_ae), .status_high_water(f_hw), .status_stall_count(f_stall));

    typedef struct {
        int         occ;
        logic [4:0] af_th;
        logic [4:0] ae_th;
        logic       exp_af;
        logic       exp_ae;
    } vec_t;

    vec_t       tbl [51];
    int         total = 0;
    int         bad = 0;
    int         acc, dlv, st, cur_occ, n;
    logic       took;
    logic [9:0] q [$];
    logic [9:0] exp3 [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Pops the model queue for a delivered beat, or flags a beat nobody sent
    task automatic expect_beat(input string nm, input logic [9:0] act);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=%0h required=none", nm, act);
        end else begin
            chk(nm, act, q.pop_front());
        end
    endtask

    initial begin
        // Threshold table: three threshold pairs at every occupancy 0..16
        for (int o = 0; o <= 16; o++) begin
            for (int c = 0; c < 3; c++) begin
                logic [4:0] aft, aet;
                aft = (c == 0) ? 5'd0 : (c == 1) ? 5'd17 : 5'd12;
                aet = (c == 0) ? 5'd0 : (c == 1) ? 5'd16 : 5'd2;
                tbl[o * 3 + c] = '{occ: o, af_th: aft, ae_th: aet,
                                   exp_af: (o >= int'(aft)), exp_ae: (o <= int'(aet))};
            end
        end
        a_sd = 8'h00; a_sk = 1'b1; a_sv = 1'b0; a_sl = 1'b0; a_su = 1'b0; a_mr = 1'b0;
        a_afth = 5'd12; a_aeth = 5'd2; a_clr = 1'b0;
        f_sd = 8'h00; f_sk = 1'b1; f_sv = 1'b0; f_sl = 1'b0; f_su = 1'b0; f_mr = 1'b0;
        f_afth = 5'd12; f_aeth = 5'd4; f_clr = 1'b0;
        do_reset();

        // Fill and thresholds: first beat parks in the output register (occ 0)
        a_sv = 1'b1; a_sd = 8'h80;
        step();
        a_sv = 1'b0;
        step();
        cur_occ = 0;
        for (int i = 0; i < 51; i++) begin
            while (cur_occ < tbl[i].occ) begin
                chk("fill_ready", a_sr, 1);
                a_sv = 1'b1; a_sd = 8'(8'h81 + cur_occ);
                step();
                a_sv = 1'b0;
                chk("lag_line", a_line, cur_occ);
                chk("lag_af", a_af, (cur_occ >= int'(a_afth)));
                cur_occ++;
            end
            a_afth = tbl[i].af_th; a_aeth = tbl[i].ae_th;
            step();
            chk("thr_line", a_line, tbl[i].occ);
            chk("thr_af", a_af, tbl[i].exp_af);
            chk("thr_ae", a_ae, tbl[i].exp_ae);
        end
        chk("full_ready", a_sr, 0);
        a_afth = 5'd12; a_aeth = 5'd2;
        step();

        // Asynchronous reset while full: everything reads zero until release
        rst_n = 1'b0;
        #1;
        chk("rst_mvalid", a_mv, 0);
        chk("rst_sready", a_sr, 0);
        chk("rst_line", a_line, 0);
        chk("rst_af", a_af, 0);
        chk("rst_ae", a_ae, 0);
        chk("rst_hw", a_hw, 0);
        chk("rst_frm", a_frm, 0);
        chk("rst_stall", a_stall, 0);
        repeat (2) step();
        chk("rst_hold_sready", a_sr, 0);
        chk("rst_hold_ae", a_ae, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", a_sr, 1);

        // Latency: accepted on edge k, visible after edge k+1
        a_mr = 1'b0; a_sv = 1'b1; a_sd = 8'hA5; a_sl = 1'b0;
        step();
        a_sv = 1'b0;
        chk("lat_k", a_mv, 0);
        step();
        chk("lat_k1_valid", a_mv, 1);
        chk("lat_k1_data", a_md, 8'hA5);
        chk("keep_ones", a_mk, 1);
        a_mr = 1'b1;
        step();
        chk("lat_consumed", a_mv, 0);

        // Random streaming against a queue model
        do_reset();
        acc = 0; dlv = 0; took = 1'b0; q.delete(); a_sv = 1'b0;
        for (int cyc = 0; cyc < 20000 && dlv < 1000; cyc++) begin
            if (took || !a_sv) begin
                if (acc < 1000 && $urandom_range(0, 3) != 0) begin
                    a_sv = 1'b1; a_sd = 8'($urandom); a_sl = 1'($urandom); a_su = 1'($urandom);
                end else begin
                    a_sv = 1'b0;
                end
            end
            a_mr = ($urandom_range(0, 99) < (((cyc / 300) % 2 == 1) ? 85 : 30));
            @(negedge clk);
            chk("ready_vs_model", a_sr, (q.size() != 17));
            took = a_sv && a_sr;
            if (a_mv && a_mr) begin
                expect_beat("stream_beat", {a_mu, a_ml, a_md});
                dlv++;
            end
            if (took) begin
                q.push_back({a_su, a_sl, a_sd});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        a_sv = 1'b0;
        chk("stream_accepted", acc, 1000);
        chk("stream_delivered", dlv, 1000);
        chk("stream_left", q.size(), 0);

        // High-water mark reaches 9 and holds after draining
        do_reset();
        a_mr = 1'b0; a_sl = 1'b0; a_su = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_sv = 1'b1; a_sd = 8'(i);
            step();
        end
        a_sv = 1'b0;
        repeat (2) step();
        chk("hw_line9", a_line, 9);
        chk("hw_peak", a_hw, 9);
        a_mr = 1'b1;
        repeat (12) step();
        chk("hw_drained_line", a_line, 0);
        chk("hw_hold", a_hw, 9);

        // Stall counter saturates at 15 with a 4-bit width
        a_mr = 1'b0; a_sv = 1'b1;
        st = 0;
        for (int c = 0; c < 200 && st < 40; c++) begin
            logic inc;
            @(negedge clk);
            inc = !a_sr;
            if (inc) st++;
            @(posedge clk);
            #1;
            if (inc && st == 10) chk("stall_10", a_stall, 10);
        end
        a_sv = 1'b0;
        chk("stall_cycles", st, 40);
        chk("stall_sat", a_stall, 15);
        step();
        chk("stall_hold", a_stall, 15);

        // stat_clear with occ=3
        a_mr = 1'b1;
        repeat (20) step();
        a_mr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_sv = 1'b1; a_sd = 8'(8'h50 + i);
            step();
        end
        a_sv = 1'b0;
        repeat (2) step();
        chk("clr_pre_line", a_line, 3);
        chk("clr_pre_hw", a_hw, 16);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("clr_hw", a_hw, 3);
        chk("clr_stall", a_stall, 0);
        step();
        chk("clr_hw_hold", a_hw, 3);

        // Frame mode: 3-beat frame held until the edge after tlast
        f_mr = 1'b1;
        exp3[0] = 10'h040; exp3[1] = 10'h041; exp3[2] = 10'h142;
        for (int i = 0; i < 3; i++) begin
            f_sv = 1'b1; f_sd = exp3[i][7:0]; f_sl = exp3[i][8];
            step();
            chk("frm_hold", f_mv, 0);
        end
        f_sv = 1'b0; f_sl = 1'b0;
        chk("frm_count_lag", f_frm, 0);
        step();
        chk("frm_k1_valid", f_mv, 1);
        chk("frm_k1_data", f_md, 8'h40);
        chk("frm_count_one", f_frm, 1);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (f_mv && f_mr) begin
                if (n < 3) chk("frm_beat", {f_mu, f_ml, f_md}, exp3[n]);
                n++;
            end
            @(posedge clk);
            #1;
        end
        chk("frm_beats", n, 3);
        chk("frm_count_zero", f_frm, 0);

        // Oversize 20-beat frame must be forced out without deadlock
        q.delete(); acc = 0; dlv = 0; took = 1'b0; f_sv = 1'b0;
        for (int cyc = 0; cyc < 400 && dlv < 20; cyc++) begin
            if (took || !f_sv) begin
                if (acc < 20) begin
                    f_sv = 1'b1; f_sd = 8'(8'hC0 + acc); f_sl = (acc == 19);
                end else begin
                    f_sv = 1'b0;
                end
            end
            @(negedge clk);
            took = f_sv && f_sr;
            if (f_mv && f_mr) begin
                expect_beat("big_beat", {f_mu, f_ml, f_md});
                dlv++;
            end
            if (took) begin
                q.push_back({f_su, f_sl, f_sd});
                acc++;
            end
            @(posedge clk);
            #1;
        end
        f_sv = 1'b0; f_sl = 1'b0;
        chk("big_delivered", dlv, 20);
        chk("big_left", q.size(), 0);
        chk("keep_ones_frm", f_mk, 1);

        // Reset mid-frame: one frame held in output, next frame half written
        f_mr = 1'b0;
        f_sv = 1'b1; f_sd = 8'h10; f_sl = 1'b0; step();
        f_sd = 8'h11; f_sl = 1'b1; step();
        f_sd = 8'h20; f_sl = 1'b0; step();
        f_sv = 1'b0;
        repeat (2) step();
        chk("mid_pre_valid", f_mv, 1);
        chk("mid_pre_frm", f_frm, 1);
        chk("mid_pre_ae", f_ae, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", f_mv, 0);
        chk("mid_ready_drop", f_sr, 0);
        step();
        chk("mid_frm", f_frm, 0);
        chk("mid_line", f_line, 0);
        chk("mid_ae", f_ae, 0);
        chk("mid_af", f_af, 0);
        chk("mid_hw", f_hw, 0);
        chk("mid_stall", f_stall, 0);
        rst_n = 1'b1;
        f_mr = 1'b1;
        q.delete(); dlv = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 2) begin
                f_sv = 1'b1; f_sd = 8'(8'h30 + c); f_sl = (c == 1);
            end else begin
                f_sv = 1'b0; f_sl = 1'b0;
            end
            @(negedge clk);
            if (c < 2) chk("post_ready", f_sr, 1);
            if (f_mv && f_mr) begin
                expect_beat("post_beat", {f_mu, f_ml, f_md});
                dlv++;
            end
            if (f_sv && f_sr) q.push_back({f_su, f_sl, f_sd});
            @(posedge clk);
            #1;
        end
        chk("post_delivered", dlv, 2);
        chk("post_frm", f_frm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
